sdf_r2_stage: RTL and testbench



---
 rtl/sdf_r2_stage.sv | 123 ++++++++++++
 tb/tb_sdf_r2_stage.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback FFT stage: bf1 butterfly, DELAY-deep feedback
// line, sample counter and registered output. Feeds the twiddle multiplier downstream.
module sdf_r2_stage #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DELAY = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_re,
    input  logic [WIDTH-1:0] in_im,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_re,
    output logic [WIDTH-1:0] out_im,
    output logic             out_diff
);

    // Counter spans one full sub-FFT (2*DELAY samples); its MSB is the phase.
    localparam int unsigned CntW = (DELAY > 1) ? $clog2(2 * DELAY) : 1;

    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             primed_q, primed_d;
    logic             phase;

    logic [WIDTH-1:0] dl_re_q [DELAY];
    logic [WIDTH-1:0] dl_im_q [DELAY];
    logic [WIDTH-1:0] head_re, head_im;
    logic [WIDTH-1:0] wr_re, wr_im;

    logic [WIDTH:0]   sum_re_w, sum_im_w, dif_re_w, dif_im_w;
    logic [WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_re_q, out_re_d;
    logic [WIDTH-1:0] out_im_q, out_im_d;
    logic             out_diff_q, out_diff_d;

    // Drop bit WIDTH-1 of the extended result: keep sign, then the low WIDTH-1 bits.
    function automatic logic [WIDTH-1:0] fold(input logic [WIDTH:0] s);
        return {s[WIDTH], s[WIDTH-2:0]};
    endfunction

    assign phase   = cnt_q[CntW-1];
    assign head_re = dl_re_q[DELAY-1];
    assign head_im = dl_im_q[DELAY-1];

    // bf1 butterfly: sign-extended sum and difference of delay-line head and input.
    always_comb begin
        sum_re_w = {head_re[WIDTH-1], head_re} + {in_re[WIDTH-1], in_re};
        sum_im_w = {head_im[WIDTH-1], head_im} + {in_im[WIDTH-1], in_im};
        dif_re_w = {head_re[WIDTH-1], head_re} - {in_re[WIDTH-1], in_re};
        dif_im_w = {head_im[WIDTH-1], head_im} - {in_im[WIDTH-1], in_im};
        sum_re   = fold(sum_re_w);
        sum_im   = fold(sum_im_w);
        dif_re   = fold(dif_re_w);
        dif_im   = fold(dif_im_w);
    end

    // Next-state: counter, priming flag, delay-line write data and output candidates.
    always_comb begin
        cnt_d       = cnt_q;
        primed_d    = primed_q;
        wr_re       = in_re;
        wr_im       = in_im;
        out_re_d    = head_re;
        out_im_d    = head_im;
        out_diff_d  = 1'b1;
        out_valid_d = in_valid & (phase | primed_q);
        if (in_valid) begin
            // 2*DELAY is a power of two, so natural overflow gives the wrap.
            cnt_d = cnt_q + CntW'(1);
            if (phase) begin
                primed_d = 1'b1;
            end
        end
        if (phase) begin
            wr_re      = dif_re;
            wr_im      = dif_im;
            out_re_d   = sum_re;
            out_im_d   = sum_im;
            out_diff_d = 1'b0;
        end
    end

    // Control and output registers; outputs only reload on accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            primed_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_diff_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            primed_q    <= primed_d;
            out_valid_q <= out_valid_d;
            if (in_valid) begin
                out_re_q   <= out_re_d;
                out_im_q   <= out_im_d;
                out_diff_q <= out_diff_d;
            end
        end
    end

    // Feedback shift register; contents are unobservable until primed, so no reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            dl_re_q[0] <= wr_re;
            dl_im_q[0] <= wr_im;
            for (int unsigned i = 1; i < DELAY; i++) begin
                dl_re_q[i] <= dl_re_q[i-1];
                dl_im_q[i] <= dl_im_q[i-1];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_diff  = out_diff_q;

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Self-checking bench for sdf_r2_stage: three instances (DELAY 4, 1, 32), scoreboard of
// expected results stamped with the cycle they must appear in.
module tb_sdf_r2_stage;

    localparam int W = 17;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         iv  [3];
    logic [W-1:0] ire [3];
    logic [W-1:0] iim [3];
    logic         ov  [3];
    logic         od  [3];
    logic [W-1:0] ore [3];
    logic [W-1:0] oim [3];

    int cyc    = 0;
    int nassert = 0;
    int nfail  = 0;

    typedef struct {
        int           stamp;
        logic [W-1:0] re;
        logic [W-1:0] im;
        logic         diff;
    } exp_t;

    exp_t         sb [3][$];
    logic [W-1:0] last_re   [3];
    logic [W-1:0] last_im   [3];
    logic         last_diff [3];
    logic         got_any   [3];

    logic [W-1:0] x1_re [64];
    logic [W-1:0] x1_im [64];
    logic [W-1:0] x2_re [64];
    logic [W-1:0] x2_im [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sdf_r2_stage #(.WIDTH(W), .DELAY(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_re(ire[0]), .in_im(iim[0]),
        .out_valid(ov[0]), .out_re(ore[0]), .out_im(oim[0]), .out_diff(od[0])
    );
    sdf_r2_stage #(.WIDTH(W), .DELAY(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_re(ire[1]), .in_im(iim[1]),
        .out_valid(ov[1]), .out_re(ore[1]), .out_im(oim[1]), .out_diff(od[1])
    );
    sdf_r2_stage #(.WIDTH(W), .DELAY(32)) u_d32 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_re(ire[2]), .in_im(iim[2]),
        .out_valid(ov[2]), .out_re(ore[2]), .out_im(oim[2]), .out_diff(od[2])
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        nassert++;
        assert (got === expv) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, got, expv);
        end
    endtask

    // Golden bf1 arithmetic: extend, add/subtract, keep sign plus low W-1 bits.
    function automatic logic [W-1:0] fold(input logic [W:0] s);
        return {s[W], s[W-2:0]};
    endfunction
    function automatic logic [W-1:0] bsum(input logic [W-1:0] a, input logic [W-1:0] b);
        return fold({a[W-1], a} + {b[W-1], b});
    endfunction
    function automatic logic [W-1:0] bdif(input logic [W-1:0] a, input logic [W-1:0] b);
        return fold({a[W-1], a} - {b[W-1], b});
    endfunction

    // Drive one cycle of stimulus on instance d (others idle).
    task automatic step(input int d, input logic v, input logic [W-1:0] re,
                        input logic [W-1:0] im);
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        iv[d]  = v;
        ire[d] = re;
        iim[d] = im;
    endtask

    // Expected result of the sample just driven: appears one clock later.
    task automatic expect_out(input int d, input logic [W-1:0] re, input logic [W-1:0] im,
                              input logic diff);
        exp_t e;
        e.stamp = cyc + 1;
        e.re    = re;
        e.im    = im;
        e.diff  = diff;
        sb[d].push_back(e);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) iv[k] = 1'b0;
        #1 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Frame 1..8 then 8 zeros on the DELAY=4 instance, optionally with a gap after each.
    task automatic run_frame_d4(input logic stall);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1'b1, (i <= 8) ? W'(i) : '0, '0);
            if (i >= 5 && i <= 8) expect_out(0, W'(2 * i - 4), '0, 1'b0);
            else if (i >= 9 && i <= 12) expect_out(0, 17'h1FFFC, '0, 1'b1);
            else if (i >= 13) expect_out(0, '0, '0, 1'b0);
            if (stall) step(0, 1'b0, '0, '0);
        end
        step(0, 1'b0, '0, '0);
        repeat (2) step(0, 1'b0, '0, '0);
    endtask

    // Monitor: pop on out_valid and compare; otherwise outputs must hold the last result.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                last_re[d]   = '0;
                last_im[d]   = '0;
                last_diff[d] = 1'b0;
                got_any[d]   = 1'b0;
                sb[d].delete();
            end else if (ov[d]) begin
                chk($sformatf("have_expectation_d%0d", d), 64'(sb[d].size() != 0), 64'd1);
                if (sb[d].size() != 0) begin
                    exp_t e;
                    e = sb[d].pop_front();
                    chk($sformatf("latency_d%0d", d), 64'(cyc), 64'(e.stamp));
                    chk($sformatf("re_d%0d", d), 64'(ore[d]), 64'(e.re));
                    chk($sformatf("im_d%0d", d), 64'(oim[d]), 64'(e.im));
                    chk($sformatf("diff_d%0d", d), 64'(od[d]), 64'(e.diff));
                    last_re[d]   = e.re;
                    last_im[d]   = e.im;
                    last_diff[d] = e.diff;
                    got_any[d]   = 1'b1;
                end
            end else if (got_any[d]) begin
                chk($sformatf("hold_d%0d", d), 64'({od[d], ore[d], oim[d]}),
                    64'({last_diff[d], last_re[d], last_im[d]}));
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k]  = 1'b0;
            ire[k] = '0;
            iim[k] = '0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid", 64'(ov[0]), 64'd0);
        chk("reset_re", 64'(ore[0]), 64'd0);
        chk("reset_diff", 64'(od[0]), 64'd0);
        rst = 1'b0;

        // Continuous frame, then the same with every other cycle idle.
        run_frame_d4(1'b0);
        do_reset();
        run_frame_d4(1'b1);
        do_reset();

        // Asynchronous reset while sample 6 is being presented.
        for (int i = 1; i <= 5; i++) step(0, 1'b1, W'(i), '0);
        step(0, 1'b1, W'(6), '0);
        #2;
        chk("pre_rst_valid", 64'(ov[0]), 64'd1);
        chk("pre_rst_re", 64'(ore[0]), 64'd6);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(ov[0]), 64'd0);
        chk("async_rst_re", 64'(ore[0]), 64'd0);
        chk("async_rst_diff", 64'(od[0]), 64'd0);
        step(0, 1'b0, '0, '0);
        @(posedge clk);
        #2 rst = 1'b0;
        run_frame_d4(1'b0);

        // DELAY=1 wrap and truncation corners.
        step(1, 1'b1, 17'h0FFFF, 17'h00005);
        step(1, 1'b1, 17'h00001, 17'h00003);
        expect_out(1, 17'h00000, 17'h00008, 1'b0);
        step(1, 1'b1, '0, '0);
        expect_out(1, 17'h0FFFE, 17'h00002, 1'b1);
        step(1, 1'b1, '0, '0);
        expect_out(1, '0, '0, 1'b0);
        step(1, 1'b1, 17'h10000, '0);
        expect_out(1, '0, '0, 1'b1);
        step(1, 1'b1, 17'h1FFFF, '0);
        expect_out(1, 17'h1FFFF, '0, 1'b0);
        repeat (3) step(1, 1'b0, '0, '0);

        // DELAY=32: two random frames then a flush, against a DIF first-stage model.
        for (int n = 0; n < 64; n++) begin
            x1_re[n] = W'($urandom);
            x1_im[n] = W'($urandom);
            x2_re[n] = W'($urandom);
            x2_im[n] = W'($urandom);
        end
        for (int n = 0; n < 64; n++) begin
            step(2, 1'b1, x1_re[n], x1_im[n]);
            if (n >= 32)
                expect_out(2, bsum(x1_re[n-32], x1_re[n]), bsum(x1_im[n-32], x1_im[n]), 1'b0);
        end
        for (int n = 0; n < 64; n++) begin
            step(2, 1'b1, x2_re[n], x2_im[n]);
            if (n < 32)
                expect_out(2, bdif(x1_re[n], x1_re[n+32]), bdif(x1_im[n], x1_im[n+32]), 1'b1);
            else
                expect_out(2, bsum(x2_re[n-32], x2_re[n]), bsum(x2_im[n-32], x2_im[n]), 1'b0);
        end
        for (int n = 0; n < 32; n++) begin
            step(2, 1'b1, '0, '0);
            expect_out(2, bdif(x2_re[n], x2_re[n+32]), bdif(x2_im[n], x2_im[n+32]), 1'b1);
        end
        repeat (4) step(2, 1'b0, '0, '0);

        for (int d = 0; d < 3; d++)
            chk($sformatf("drained_d%0d", d), 64'(sb[d].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
